// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and fetch counter,
// with a RUN/HALTED state machine driven by hazard-unit and memory controls.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        pc_stall,
  input  logic        fetch_stall,
  input  logic        fetch_flush,
  input  logic        mem_wait,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_npc, w_npc_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_count;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_load;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = (pc_sel != 2'b00);

  // Redirect target selection from the pc_sel encoding.
  always_comb begin
    w_target = w_pc_plus4;
    case (pc_sel)
      2'b01:   w_target = branch_target;
      2'b10:   w_target = jump_target;
      2'b11:   w_target = jr_target;
      default: w_target = w_pc_plus4;
    endcase
  end

  // Next-state: halting is deferred while a data access is pending.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (halt && !mem_wait) w_state_nxt = HALTED;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  // Next PC: mem_wait freezes, redirect beats pc_stall and a pending miss.
  always_comb begin
    w_pc_nxt = r_pc;
    if (r_state == HALTED || mem_wait) w_pc_nxt = r_pc;
    else if (w_redirect)               w_pc_nxt = w_target;
    else if (pc_stall)                 w_pc_nxt = r_pc;
    else if (ihit)                     w_pc_nxt = w_pc_plus4;
  end

  // Next IF/ID contents: flush beats stall; anything not loaded becomes a bubble.
  always_comb begin
    w_instr_nxt = '0;
    w_npc_nxt   = '0;
    w_valid_nxt = 1'b0;
    w_load      = 1'b0;
    if (mem_wait) begin
      w_instr_nxt = r_instr;
      w_npc_nxt   = r_npc;
      w_valid_nxt = r_valid;
    end else if (r_state == HALTED || fetch_flush || w_redirect) begin
      w_instr_nxt = '0;
    end else if (fetch_stall) begin
      w_instr_nxt = r_instr;
      w_npc_nxt   = r_npc;
      w_valid_nxt = r_valid;
    end else if (ihit) begin
      w_instr_nxt = imemload;
      w_npc_nxt   = w_pc_plus4;
      w_valid_nxt = 1'b1;
      w_load      = 1'b1;
    end
  end

  // State, PC, IF/ID latch and fetch counter registers.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_state <= RUN;
      r_pc    <= PC_INIT;
      r_instr <= '0;
      r_npc   <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_npc   <= w_npc_nxt;
      r_valid <= w_valid_nxt;
      if (w_load) r_count <= r_count + 32'd1;
    end
  end

  assign imemREN     = (r_state == RUN);
  assign imemaddr    = r_pc;
  assign ifid_instr  = r_instr;
  assign ifid_npc    = r_npc;
  assign ifid_valid  = r_valid;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver pushes hand-computed post-edge
// expectations; a monitor pops one per cycle and compares against the DUT.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        rstA, rstB;
  logic        ihit, pc_stall, fetch_stall, fetch_flush, mem_wait, halt;
  logic [31:0] imemload;
  logic [1:0]  pc_sel;
  logic [31:0] branch_target, jump_target, jr_target;

  logic        enA, enB, vA, vB;
  logic [31:0] addrA, addrB, instrA, instrB, npcA, npcB, cntA, cntB;

  typedef struct {
    bit          dut_b;
    logic        en;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(32'h00000000)) dutA (
    .CLK(CLK), .nRST(rstA), .ihit(ihit), .imemload(imemload),
    .pc_stall(pc_stall), .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
    .mem_wait(mem_wait), .pc_sel(pc_sel), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .halt(halt),
    .imemREN(enA), .imemaddr(addrA), .ifid_instr(instrA), .ifid_npc(npcA),
    .ifid_valid(vA), .fetch_count(cntA));

  fetch_stage #(.PC_INIT(32'hFFFFFFFC)) dutB (
    .CLK(CLK), .nRST(rstB), .ihit(ihit), .imemload(imemload),
    .pc_stall(pc_stall), .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
    .mem_wait(mem_wait), .pc_sel(pc_sel), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .halt(halt),
    .imemREN(enB), .imemaddr(addrB), .ifid_instr(instrB), .ifid_npc(npcB),
    .ifid_valid(vB), .fetch_count(cntB));

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, checked shortly after the rising edge.
  int mstep = 0;
  always @(posedge CLK) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      mstep++;
      if (!e.dut_b) begin
        chk("imemREN",     mstep, {31'd0, enA}, {31'd0, e.en});
        chk("imemaddr",    mstep, addrA,        e.addr);
        chk("ifid_instr",  mstep, instrA,       e.instr);
        chk("ifid_npc",    mstep, npcA,         e.npc);
        chk("ifid_valid",  mstep, {31'd0, vA},  {31'd0, e.valid});
        chk("fetch_count", mstep, cntA,         e.cnt);
      end else begin
        chk("imemREN",     mstep, {31'd0, enB}, {31'd0, e.en});
        chk("imemaddr",    mstep, addrB,        e.addr);
        chk("ifid_instr",  mstep, instrB,       e.instr);
        chk("ifid_npc",    mstep, npcB,         e.npc);
        chk("ifid_valid",  mstep, {31'd0, vB},  {31'd0, e.valid});
        chk("fetch_count", mstep, cntB,         e.cnt);
      end
    end
  end

  // Driver: apply one cycle of inputs and queue the state expected after the edge.
  task automatic step(input bit b, input logic ra, input logic rb, input logic ih,
                      input logic [31:0] ld, input logic ps, input logic fs,
                      input logic ff, input logic mw, input logic [1:0] sel,
                      input logic hl, input logic e_en, input logic [31:0] e_addr,
                      input logic [31:0] e_instr, input logic [31:0] e_npc,
                      input logic e_v, input logic [31:0] e_cnt);
    exp_t e;
    @(negedge CLK);
    rstA = ra; rstB = rb; ihit = ih; imemload = ld; pc_stall = ps;
    fetch_stall = fs; fetch_flush = ff; mem_wait = mw; pc_sel = sel; halt = hl;
    e.dut_b = b; e.en = e_en; e.addr = e_addr; e.instr = e_instr;
    e.npc = e_npc; e.valid = e_v; e.cnt = e_cnt;
    q.push_back(e);
  endtask

  localparam logic [31:0] W0 = 32'h20010005;

  initial begin
    rstA = 1; rstB = 1; ihit = 0; imemload = '0; pc_stall = 0; fetch_stall = 0;
    fetch_flush = 0; mem_wait = 0; pc_sel = 2'b00; halt = 0;
    branch_target = 32'h40; jump_target = 32'h200; jr_target = 32'h100;

    //   b  rA rB ih load          ps fs ff mw sel    hl | en addr          instr         npc           v  cnt
    // Reset and straight-line fetch
    step(0, 1, 1, 1, W0,           0, 0, 0, 0, 2'b00, 0,   1, 32'h0,        32'h0,        32'h0,        0, 32'd0);
    step(0, 0, 1, 1, W0,           0, 0, 0, 0, 2'b00, 0,   1, 32'h4,        W0,           32'h4,        1, 32'd1);
    step(0, 0, 1, 1, W0,           0, 0, 0, 0, 2'b00, 0,   1, 32'h8,        W0,           32'h8,        1, 32'd2);
    // Three-cycle miss at PC=8
    step(0, 0, 1, 0, W0,           0, 0, 0, 0, 2'b00, 0,   1, 32'h8,        32'h0,        32'h0,        0, 32'd2);
    step(0, 0, 1, 0, W0,           0, 0, 0, 0, 2'b00, 0,   1, 32'h8,        32'h0,        32'h0,        0, 32'd2);
    step(0, 0, 1, 0, W0,           0, 0, 0, 0, 2'b00, 0,   1, 32'h8,        32'h0,        32'h0,        0, 32'd2);
    step(0, 0, 1, 1, 32'h8C220000, 0, 0, 0, 0, 2'b00, 0,   1, 32'hC,        32'h8C220000, 32'hC,        1, 32'd3);
    // Load-use stall at PC=12, then stall+flush together
    step(0, 0, 1, 1, 32'hAAAA5555, 1, 1, 0, 0, 2'b00, 0,   1, 32'hC,        32'h8C220000, 32'hC,        1, 32'd3);
    step(0, 0, 1, 1, 32'hAAAA5555, 1, 1, 1, 0, 2'b00, 0,   1, 32'hC,        32'h0,        32'h0,        0, 32'd3);
    step(0, 0, 1, 1, 32'h00000001, 0, 0, 0, 0, 2'b00, 0,   1, 32'h10,       32'h1,        32'h10,       1, 32'd4);
    // Branch with flush; jr redirect beating pc_stall during a miss
    step(0, 0, 1, 1, 32'hBBBBBBBB, 0, 0, 1, 0, 2'b01, 0,   1, 32'h40,       32'h0,        32'h0,        0, 32'd4);
    step(0, 0, 1, 0, 32'hCCCCCCCC, 1, 0, 0, 0, 2'b11, 0,   1, 32'h100,      32'h0,        32'h0,        0, 32'd4);
    step(0, 0, 1, 1, 32'h11111111, 0, 0, 0, 0, 2'b00, 0,   1, 32'h104,      32'h11111111, 32'h104,      1, 32'd5);
    // mem_wait freezes everything, including a pending halt + jump
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 1, 32'hDDDDDDDD, 0, 0, 0, 1, 2'b10, 1, 1, 32'h104,      32'h11111111, 32'h104,      1, 32'd5);
    step(0, 0, 1, 1, 32'hDDDDDDDD, 0, 0, 0, 0, 2'b10, 1,   0, 32'h200,      32'h0,        32'h0,        0, 32'd5);
    // HALTED ignores hits and redirects
    step(0, 0, 1, 1, 32'hEEEEEEEE, 0, 0, 0, 0, 2'b00, 0,   0, 32'h200,      32'h0,        32'h0,        0, 32'd5);
    step(0, 0, 1, 1, 32'hEEEEEEEE, 0, 0, 0, 0, 2'b01, 0,   0, 32'h200,      32'h0,        32'h0,        0, 32'd5);
    // Reset out of HALTED, first fetch at PC_INIT, reset mid-miss
    step(0, 1, 1, 1, 32'hEEEEEEEE, 0, 0, 0, 0, 2'b00, 1,   1, 32'h0,        32'h0,        32'h0,        0, 32'd0);
    step(0, 0, 1, 1, 32'h22222222, 0, 0, 0, 0, 2'b00, 0,   1, 32'h4,        32'h22222222, 32'h4,        1, 32'd1);
    step(0, 1, 1, 0, 32'h22222222, 0, 0, 0, 0, 2'b00, 0,   1, 32'h0,        32'h0,        32'h0,        0, 32'd0);

    // PC wrap instance (PC_INIT = FFFFFFFC); dutA held in reset
    step(1, 1, 1, 1, 32'h33333333, 0, 0, 0, 0, 2'b00, 0,   1, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 32'd0);
    step(1, 1, 0, 1, 32'h33333333, 0, 0, 0, 0, 2'b00, 0,   1, 32'h0,        32'h33333333, 32'h0,        1, 32'd1);
    step(1, 1, 0, 1, 32'h44444444, 0, 0, 0, 0, 2'b00, 1,   0, 32'h4,        32'h44444444, 32'h4,        1, 32'd2);
    step(1, 1, 0, 1, 32'h55555555, 0, 0, 0, 0, 2'b00, 0,   0, 32'h4,        32'h0,        32'h0,        0, 32'd2);
    step(1, 1, 1, 1, 32'h55555555, 0, 0, 0, 0, 2'b00, 0,   1, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 32'd0);

    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
